// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port
// among NREQ producers; never writes into a full FIFO.
//
// Ports:
//   clk          rising-edge clock shared with the FIFO
//   rst          asynchronous active-high reset
//   req          per-requester "word available" (held until accepted)
//   req_data     requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt          registered one-hot grant, zero when idle
//   fifo_full    FIFO full flag, stalls the current burst
//   fifo_al_full FIFO almost-full flag, blocks new grants
//   fifo_wr      FIFO write strobe
//   fifo_data    FIFO write data (zero when idle)
//   owner        current grantee, holds last grantee when idle
//   busy         high while a grant is active
module fifo_wr_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            gnt,
  input  logic                       fifo_full,
  input  logic                       fifo_al_full,
  output logic                       fifo_wr,
  output logic [DATA_WIDTH-1:0]      fifo_data,
  output logic [$clog2(NREQ)-1:0]    owner,
  output logic                       busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state;
  state_t          state_d;
  logic [NREQ-1:0] gnt_d;
  logic [IW-1:0]   owner_d;
  logic [IW-1:0]   last;
  logic [IW-1:0]   last_d;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic            found;
  logic            xfer;
  logic            rel;
  logic            decide;

  assign busy      = |gnt;
  assign xfer      = req[owner] & gnt[owner] & ~fifo_full;
  assign fifo_wr   = xfer;
  assign fifo_data = busy ?
    req_data[owner*DATA_WIDTH +: DATA_WIDTH] : '0;

  assign cnt_inc = cnt + CW'(1);

  // A burst ends on its last accepted word, or as soon as the
  // grantee has nothing to offer.
  assign rel = (state == GRANT) &
    ((xfer & (cnt_inc == CW'(BURST))) | ~req[owner]);

  assign decide = (state == IDLE) | rel;

  // Rotating search starting just after the last grantee; the
  // final iteration wraps back onto the last grantee itself, so a
  // lone requester is re-granted without a bubble. NREQ is a power
  // of two, so the IW-bit add wraps naturally.
  always_comb begin
    found = 1'b0;
    pick  = last;
    idx   = last;
    for (int i = 1; i <= NREQ; i++) begin
      idx = last + IW'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    owner_d = owner;
    last_d  = last;
    cnt_d   = cnt;
    if (xfer) begin
      cnt_d = cnt_inc;
    end
    if (decide) begin
      cnt_d = '0;
      if (found && !fifo_al_full) begin
        state_d     = GRANT;
        gnt_d       = '0;
        gnt_d[pick] = 1'b1;
        owner_d     = pick;
        last_d      = pick;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      last  <= IW'(NREQ - 1);
      cnt   <= '0;
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
      owner <= owner_d;
      last  <= last_d;
      cnt   <= cnt_d;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `fifo_buffer_syn` write port among NREQ producers. It grants bursts of up to BURST words per requester and drives the FIFO `wr`/`data` inputs directly. It honours the FIFO `full` and `al_full` flags so that no write is ever issued into a full buffer. It sits between the producer blocks and the FIFO write side; the FIFO read side is untouched.

## Interface
Parameters:
- NREQ, 4: number of requesters; power of two, 2..8.
- DATA_WIDTH, 8: word width; matches the FIFO `DATA_WIDTH`.
- BURST, 4: maximum words per grant; ≥1.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock, shared with the FIFO.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester "word available"; must stay high with stable data until the word is accepted.
- req_data  in  NREQ*DATA_WIDTH  requester i's word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  out  NREQ  registered one-hot grant; all zeros when idle.
- fifo_full  in  1  FIFO `full`.
- fifo_al_full  in  1  FIFO `al_full`.
- fifo_wr  out  1  to FIFO `wr`.
- fifo_data  out  DATA_WIDTH  to FIFO `data`.
- owner  out  clog2(NREQ)  index of the current grantee; holds the last grantee when idle.
- busy  out  1  high while a grant is active (equals `|gnt`).

## Operation
- States:
  - IDLE: `gnt`=0.
  - GRANT: exactly one `gnt` bit set.
- Transfer condition: `xfer` = `req[owner] & gnt[owner] & ~fifo_full`.
  - `fifo_wr` = `xfer`, combinational.
  - `fifo_data` = `req_data` slice of `owner` when `busy`, else 0.
- Beat counter, width clog2(BURST+1):
  - Cleared on each new grant.
  - +1 on each `xfer`.
  - Unchanged on stall (`fifo_full`, or `req[owner]` low).
- Release from GRANT occurs at the clock edge where either:
  - `xfer` happens and the count reaches BURST, or
  - `req[owner]` is low.
- Arbitration is evaluated in IDLE and at every release edge:
  - Search `req` starting at index `last+1` and wrapping NREQ-1 → 0. Here `last` is the most recent grantee.
  - The first set bit wins.
  - The releasing requester is therefore lowest priority, but is re-granted with no bubble if it is the only one requesting.
- No new grant is issued while `fifo_al_full`=1: the block stays or returns to IDLE. A burst already granted continues under `fifo_al_full`; only `fifo_full` stalls it.
- `req` bits outside the current grantee are ignored during GRANT.

## Timing
- Reset values: `gnt`=0, `busy`=0, `owner`=0, `fifo_wr`=0, `fifo_data`=0, beat count 0, state IDLE.
  - `last` resets to NREQ-1, so the first grant after reset prefers req0.
  - Reset asserted mid-burst clears everything asynchronously. An in-flight word is not written.
- Grant latency: `req` rising in IDLE gives `gnt` high on the next edge. The first `fifo_wr` is in the same cycle `gnt` is high, if not full.
- Back-to-back bursts: `gnt` moves to the next requester at the release edge, with no idle cycle. Throughput is 1 word/cycle while requests persist and the FIFO is not full.
- `fifo_full` high: `fifo_wr`=0 that cycle, and `gnt`, `owner` and the beat count all hold.
- `req[owner]` low during GRANT: no write that cycle, and release occurs at that edge.
- The `fifo_al_full` check applies only at grant decision edges. It is sampled at the same edge as the release.

## Test plan
1. Reset, then req=4'b0100 held for 6 accepted words:
   - `gnt`=4'b0100 one cycle after `req`.
   - 6 consecutive `fifo_wr` pulses carrying the req2 data in order.
   - Internal re-grant after 4 words with no bubble.
   - `gnt`→0 the cycle after `req` drops.
2. req=4'b1111 held continuously:
   - Grant order 0,1,2,3,0, each owner for exactly 4 `fifo_wr` cycles.
   - `fifo_wr` high every cycle after the first grant.
   - `fifo_data` matches the owner's slice.
3. Mid-burst, after 2 words from req1, `fifo_full`=1 for 3 cycles:
   - `fifo_wr`=0 and `gnt`=4'b0010 held for those 3 cycles.
   - The remaining 2 words are written afterwards, then the grant moves on.
4. `fifo_al_full`=1 while IDLE with req=4'b0011:
   - `gnt` stays 0.
   - Drop `fifo_al_full`: `gnt`=4'b0001 on the next edge.
   - `fifo_al_full` rising mid-burst does not cut the burst short.
5. req3 drops after 2 of 4 words while req0 is pending:
   - Release at that edge; `gnt`=4'b0001 next cycle.
   - Exactly 2 req3 words in the FIFO.
6. `rst` pulsed mid-burst between clock edges:
   - `gnt`, `fifo_wr` and `busy` go to 0 immediately.
   - After release of reset with req=4'b1010, the first grant goes to req1.
